// File: rtl/ir_cmd_queue.sv
// IR command front-end: NEC frame validation, address filtering, key lookup,
// held-key repeat suppression and a valid/ready output queue of state indices.
module ir_cmd_queue #(
    parameter int                    NUM_CMDS    = 8,
    parameter int                    STATE_W     = 3,
    parameter logic [NUM_CMDS*8-1:0] CMD_CODES   = 64'h07_09_15_16_0C_18_46_45,
    parameter bit                    CHECK_ADDR  = 1'b1,
    parameter logic [7:0]            DEV_ADDR    = 8'h00,
    parameter int                    HOLDOFF_CYC = 5_000_000,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [31:0]                   ir_data,
    input  logic                          data_ready,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [STATE_W-1:0]            out_state,
    output logic [STATE_W-1:0]            state_control,
    output logic                          cmd_hit,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [7:0]                    err_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TMR_W = $clog2(HOLDOFF_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(HOLDOFF_CYC - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    // Stage 0: rising-edge detect on data_ready and frame capture
    logic        r_dr_prev;
    logic        r_armed;
    logic        r_vld_p0;
    logic [31:0] r_frame_p0;
    logic        w_edge;

    // A level already high when reset releases is not a frame; wait for a low first.
    assign w_edge = data_ready & ~r_dr_prev & r_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dr_prev <= 1'b0;
            r_armed   <= 1'b0;
            r_vld_p0  <= 1'b0;
        end else begin
            r_dr_prev <= data_ready;
            r_armed   <= r_armed | ~data_ready;
            r_vld_p0  <= w_edge;
        end
    end

    always_ff @(posedge clk) begin
        if (w_edge) begin
            r_frame_p0 <= ir_data;
        end
    end

    // Stage 1: classify, look up and apply repeat suppression
    logic [7:0]         w_addr;
    logic [7:0]         w_addr_inv;
    logic [7:0]         w_cmd;
    logic [7:0]         w_cmd_inv;
    logic               w_inv_ok;
    logic               w_addr_ok;
    logic               w_key_hit;
    logic [STATE_W-1:0] w_key_idx;
    logic               w_frame_ok;
    logic               w_valid;
    logic               w_bad;
    logic               w_tmr_exp;
    logic               w_repeat;
    logic               w_accept;

    logic [TMR_W-1:0]   r_timer;
    logic               r_last_vld;
    logic [7:0]         r_last_code;
    logic               r_vld_p1;
    logic [STATE_W-1:0] r_idx_p1;

    assign w_addr     = r_frame_p0[7:0];
    assign w_addr_inv = r_frame_p0[15:8];
    assign w_cmd      = r_frame_p0[23:16];
    assign w_cmd_inv  = r_frame_p0[31:24];

    assign w_inv_ok  = (w_cmd == ~w_cmd_inv);
    assign w_addr_ok = !CHECK_ADDR || ((w_addr == DEV_ADDR) && (w_addr_inv == ~w_addr));

    // Descending scan so the lowest matching index wins.
    always_comb begin
        w_key_hit = 1'b0;
        w_key_idx = '0;
        for (int i = NUM_CMDS - 1; i >= 0; i--) begin
            if (CMD_CODES[8*i +: 8] == w_cmd) begin
                w_key_hit = 1'b1;
                w_key_idx = STATE_W'(i);
            end
        end
    end

    assign w_frame_ok = w_inv_ok & w_addr_ok & w_key_hit;
    assign w_valid    = r_vld_p0 & w_frame_ok;
    assign w_bad      = r_vld_p0 & ~w_frame_ok;
    assign w_tmr_exp  = (r_timer == '0);
    assign w_repeat   = r_last_vld && (r_last_code == w_cmd) && !w_tmr_exp;
    assign w_accept   = w_valid & ~w_repeat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer     <= '0;
            r_last_vld  <= 1'b0;
            r_last_code <= 8'h00;
            r_vld_p1    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            r_vld_p1  <= w_accept;
            frame_err <= w_bad;
            // Every valid frame, suppressed or not, restarts the hold-off window.
            if (w_valid) begin
                r_timer <= TMR_LOAD;
            end else if (!w_tmr_exp) begin
                r_timer <= r_timer - 1'b1;
            end
            if (w_accept) begin
                r_last_vld  <= 1'b1;
                r_last_code <= w_cmd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx_p1 <= w_key_idx;
        end
    end

    // Stage 2: queue write, status pulses and error counter
    logic [STATE_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_ovf;
    logic [LVL_W-1:0]   w_lvl_after_pop;
    logic [PTR_W-1:0]   w_rd_next;

    assign w_pop  = out_valid & out_ready;
    assign w_full = (fifo_level == LVL_FULL);
    // A pop in the same cycle frees the slot, so a full queue still takes the push.
    assign w_push = r_vld_p1 & (~w_full | w_pop);
    assign w_ovf  = r_vld_p1 & w_full & ~w_pop;

    assign w_lvl_after_pop = fifo_level - LVL_W'(w_pop);
    assign w_rd_next       = r_rd_ptr + PTR_W'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_hit       <= 1'b0;
            overflow      <= 1'b0;
            state_control <= '0;
            err_cnt       <= 8'h00;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            fifo_level    <= '0;
        end else begin
            cmd_hit  <= w_push;
            overflow <= w_ovf;
            if (r_vld_p1) begin
                state_control <= r_idx_p1;
            end
            err_cnt    <= sat_add(err_cnt, {1'b0, w_bad} + {1'b0, w_ovf});
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr   <= w_rd_next;
            fifo_level <= fifo_level + LVL_W'(w_push) - LVL_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_idx_p1;
        end
    end

    // Output register: head after this cycle's pop; a same-cycle push shows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_state <= '0;
        end else begin
            out_valid <= (w_lvl_after_pop != '0);
            if (w_lvl_after_pop != '0) begin
                out_state <= r_mem[w_rd_next];
            end
        end
    end

endmodule
